// File: rtl/i2c_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a single I2C master.
// Runs one transaction per grant and reports completion as a done (ACK) or err (NACK/timeout) pulse.
module i2c_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_wr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [7:0]        m_addr,
  output logic [7:0]        m_data,
  output logic              m_wr,
  output logic              m_run,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack
);

  localparam int          IW        = $clog2(NREQ);
  localparam logic [9:0]  TIMER_MAX = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_DONE,
    COMPLETE
  } state_t;

  state_t         state, next_state;
  logic [9:0]     timer;
  logic [IW-1:0]  last;
  logic [IW-1:0]  winner;
  logic [IW-1:0]  idx;
  logic           found;
  logic           timer_hit;
  logic           arb_go;
  logic           clear_timer;
  logic           set_done;
  logic           set_err;

  assign timer_hit = (timer == TIMER_MAX);

  // Round-robin search: the first set req bit at or after last+1 wins.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + IW'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    m_run       = 1'b0;
    arb_go      = 1'b0;
    clear_timer = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) next_state = ARB;
      end
      ARB: begin
        if (|req) begin
          arb_go      = 1'b1;
          clear_timer = 1'b1;
          next_state  = LAUNCH;
        end else begin
          next_state = IDLE;
        end
      end
      LAUNCH: begin
        // m_busy means the master has taken the request; it wins over an expiring timer.
        if (m_busy) begin
          clear_timer = 1'b1;
          next_state  = WAIT_DONE;
        end else if (timer_hit) begin
          set_err    = 1'b1;
          next_state = COMPLETE;
        end else begin
          m_run = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (m_done) begin
          set_done   = !m_nack;
          set_err    = m_nack;
          next_state = COMPLETE;
        end else if (timer_hit) begin
          set_err    = 1'b1;
          next_state = COMPLETE;
        end
      end
      COMPLETE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      timer <= '0;
    end else if (clear_timer) begin
      timer <= '0;
    end else if (state == LAUNCH || state == WAIT_DONE) begin
      timer <= timer + 10'd1;
    end else begin
      timer <= '0;
    end
  end

  // Grant and master-side fields are captured once in ARB and held until COMPLETE.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      gnt    <= '0;
      done   <= '0;
      err    <= '0;
      m_addr <= '0;
      m_data <= '0;
      m_wr   <= 1'b0;
      last   <= IW'(NREQ - 1);
    end else begin
      done <= '0;
      err  <= '0;
      if (arb_go) begin
        gnt    <= NREQ'(1) << winner;
        m_addr <= req_addr[int'(winner)*8 +: 8];
        m_data <= req_data[int'(winner)*8 +: 8];
        m_wr   <= req_wr[winner];
        last   <= winner;
      end
      if (set_done) done <= gnt;
      if (set_err)  err  <= gnt;
      if (state == COMPLETE) gnt <= '0;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter: single write, NACK, fairness,
// launch timeout, done/timeout collision and reset mid-transaction.
module tb_i2c_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_wr;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [7:0]  m_addr;
  logic [7:0]  m_data;
  logic        m_wr;
  logic        m_run;
  logic        m_busy;
  logic        m_done;
  logic        m_nack;

  int vectors     = 0;
  int miscompares = 0;

  i2c_arbiter #(.NREQ(4), .TIMEOUT(1023)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_wr   (req_wr),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_wr     (m_wr),
    .m_run    (m_run),
    .m_busy   (m_busy),
    .m_done   (m_done),
    .m_nack   (m_nack)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction: ARB, LAUNCH with m_busy 3 cycles after m_run, one WAIT_DONE cycle, COMPLETE.
  task automatic applyStimulus(input string tag, input logic [3:0] reqv, input logic nack,
                               input logic [3:0] expGnt, input logic [7:0] expAddr,
                               input logic [7:0] expData, input logic expWr, input bit releaseReq);
    logic [31:0] saveAddr;
    logic [31:0] saveData;
    logic [3:0]  saveWr;
    req = reqv;
    step();
    checkOutput({tag, " arb gnt"}, 32'(gnt), 32'h0);
    step();
    checkOutput({tag, " gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, " m_addr"}, 32'(m_addr), 32'(expAddr));
    checkOutput({tag, " m_data"}, 32'(m_data), 32'(expData));
    checkOutput({tag, " m_wr"}, 32'(m_wr), 32'(expWr));
    checkOutput({tag, " m_run"}, 32'(m_run), 32'h1);
    saveAddr = req_addr;
    saveData = req_data;
    saveWr   = req_wr;
    req_addr = ~req_addr;
    req_data = ~req_data;
    req_wr   = ~req_wr;
    step();
    step();
    checkOutput({tag, " m_run held"}, 32'(m_run), 32'h1);
    step();
    m_busy = 1'b1;
    #1;
    checkOutput({tag, " m_run on busy"}, 32'(m_run), 32'h0);
    step();
    m_done = 1'b1;
    m_nack = nack;
    step();
    m_done = 1'b0;
    m_nack = 1'b0;
    m_busy = 1'b0;
    checkOutput({tag, " done"}, 32'(done), nack ? 32'h0 : 32'(expGnt));
    checkOutput({tag, " err"}, 32'(err), nack ? 32'(expGnt) : 32'h0);
    checkOutput({tag, " complete gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, " stable addr"}, 32'(m_addr), 32'(expAddr));
    checkOutput({tag, " stable data"}, 32'(m_data), 32'(expData));
    req_addr = saveAddr;
    req_data = saveData;
    req_wr   = saveWr;
    if (releaseReq) req = 4'h0;
    step();
    checkOutput({tag, " idle done"}, 32'(done), 32'h0);
    checkOutput({tag, " idle err"}, 32'(err), 32'h0);
    checkOutput({tag, " idle gnt"}, 32'(gnt), 32'h0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " gnt"}, 32'(gnt), 32'h0);
    checkOutput({tag, " done"}, 32'(done), 32'h0);
    checkOutput({tag, " err"}, 32'(err), 32'h0);
    checkOutput({tag, " m_run"}, 32'(m_run), 32'h0);
    checkOutput({tag, " m_addr"}, 32'(m_addr), 32'h0);
    checkOutput({tag, " m_data"}, 32'(m_data), 32'h0);
    checkOutput({tag, " m_wr"}, 32'(m_wr), 32'h0);
  endtask

  initial begin
    logic [3:0] wrTab;
    int         n;
    rst      = 1'b0;
    req      = 4'h0;
    req_addr = 32'h0;
    req_data = 32'h0;
    req_wr   = 4'h0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_nack   = 1'b0;
    step();
    step();
    checkResetOutputs("reset");
    rst = 1'b1;
    step();

    $display("[TB] single write");
    req_addr = 32'h0000_0050;
    req_data = 32'h0000_00A5;
    req_wr   = 4'b0000;
    applyStimulus("write", 4'b0001, 1'b0, 4'b0001, 8'h50, 8'hA5, 1'b0, 1'b1);

    $display("[TB] nack");
    req_addr = 32'h003C_0000;
    req_data = 32'h0077_0000;
    req_wr   = 4'b0100;
    applyStimulus("nack", 4'b0100, 1'b1, 4'b0100, 8'h3C, 8'h77, 1'b1, 1'b1);

    $display("[TB] fairness");
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    req_addr = 32'h4332_2110;
    req_data = 32'hB3B2_B1B0;
    wrTab    = 4'b0101;
    req_wr   = wrTab;
    for (int i = 0; i < 5; i++) begin
      int r;
      r = i % 4;
      applyStimulus($sformatf("fair%0d", i), 4'hF, 1'b0, 4'(1 << r),
                    8'h10 + 8'(r * 17), 8'hB0 + 8'(r), wrTab[r], i == 4);
    end

    $display("[TB] launch timeout");
    req_addr = 32'h0000_5A00;
    req_data = 32'h0000_1100;
    req_wr   = 4'b0000;
    req      = 4'b0010;
    step();
    step();
    checkOutput("tmo gnt", 32'(gnt), 32'h2);
    n = 0;
    while (m_run && n < 2000) begin
      n++;
      m_done = (n == 5);
      step();
    end
    m_done = 1'b0;
    checkOutput("tmo m_run cycles", 32'(n), 32'd1023);
    checkOutput("tmo pre gnt", 32'(gnt), 32'h2);
    step();
    checkOutput("tmo err", 32'(err), 32'h2);
    checkOutput("tmo done", 32'(done), 32'h0);
    req = 4'h0;
    step();
    checkOutput("tmo idle gnt", 32'(gnt), 32'h0);
    checkOutput("tmo idle m_run", 32'(m_run), 32'h0);
    checkOutput("tmo idle err", 32'(err), 32'h0);

    $display("[TB] done/timeout collision");
    req_addr = 32'h6800_0000;
    req_data = 32'h9900_0000;
    req      = 4'b1000;
    step();
    step();
    checkOutput("coll gnt", 32'(gnt), 32'h8);
    m_busy = 1'b1;
    #1;
    checkOutput("coll m_run", 32'(m_run), 32'h0);
    step();
    for (int i = 0; i < 1023; i++) step();
    m_done = 1'b1;
    m_nack = 1'b0;
    step();
    m_done = 1'b0;
    m_busy = 1'b0;
    checkOutput("coll done", 32'(done), 32'h8);
    checkOutput("coll err", 32'(err), 32'h0);
    req = 4'h0;
    step();
    checkOutput("coll idle done", 32'(done), 32'h0);
    checkOutput("coll idle err", 32'(err), 32'h0);

    $display("[TB] reset mid-transaction");
    req_addr = 32'h002A_0000;
    req_data = 32'h005C_0000;
    req_wr   = 4'b0100;
    req      = 4'b0100;
    step();
    step();
    checkOutput("rmid gnt", 32'(gnt), 32'h4);
    checkOutput("rmid m_wr", 32'(m_wr), 32'h1);
    m_busy = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checkResetOutputs("rmid");
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    m_busy = 1'b0;
    checkOutput("rmid no done", 32'(done), 32'h0);
    checkOutput("rmid no err", 32'(err), 32'h0);
    rst = 1'b1;
    req = 4'hF;
    step();
    step();
    checkOutput("rmid restart gnt", 32'(gnt), 32'h1);
    req = 4'h0;
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
